countdown60_timer: RTL and testbench

COUNTDOWN60_TIMER -- requirements
Module: countdown60_timer

---
 rtl/countdown60_timer_pkg.sv | 32 +++
 rtl/countdown60_timer_bcd_down_digit.sv | 27 ++
 rtl/week08_7segment.sv | 25 ++
 rtl/countdown60_timer.sv | 130 +++++++++++++
 tb/tb_countdown60_timer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/countdown60_timer_pkg.sv
// Shared types and constants for the HH:MM:SS BCD countdown timer.
// Digit index 0..5 runs SEC1, SEC10, MIN1, MIN10, HOUR1, HOUR10.
package countdown60_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  localparam int BCD_UNIT_MAX     = 9;
  localparam int BCD_TENS_MAX     = 5;
  localparam int HOUR_MAX_DEFAULT = 11;
  localparam int NUM_DIGITS       = 6;

  // Only the minute and second tens digits wrap at 5; HOUR10 never wraps
  // because the count stops at 00:00:00.
  function automatic int digit_max(input int idx);
    return (idx == 1 || idx == 3) ? BCD_TENS_MAX : BCD_UNIT_MAX;
  endfunction

  function automatic logic bcd_ok(input logic [7:0] val, input int max_dec);
    int tens;
    int units;
    tens  = int'(val[7:4]);
    units = int'(val[3:0]);
    return (tens <= BCD_UNIT_MAX) && (units <= BCD_UNIT_MAX) &&
           ((tens * 10 + units) <= max_dec);
  endfunction

endpackage

// File: rtl/countdown60_timer_bcd_down_digit.sv
// One BCD down-counting digit: wraps 0 -> MAX and asserts borrow on that wrap.
// Load has priority over the enable.
module bcd_down_digit #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       borrow
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= ld_val;
    end else if (en) begin
      q <= (q == 4'd0) ? 4'(MAX) : q - 4'd1;
    end
  end

  assign borrow = en && (q == 4'd0);

endmodule

// File: rtl/week08_7segment.sv
// BCD to seven-segment decoder, active-high segments ordered {g,f,e,d,c,b,a}.
// Codes above 9 blank the display.
module week08_7segment (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (bcd)
      4'd0: seg = 7'h3F;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5B;
      4'd3: seg = 7'h4F;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6D;
      4'd6: seg = 7'h7D;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7F;
      4'd9: seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/countdown60_timer.sv
// HH:MM:SS BCD countdown timer with load/start/pause strobes, alarm and
// load-error pulses, and seven-segment outputs per digit.
module countdown60_timer
  import countdown60_timer_pkg::*;
#(
  parameter int HOUR_MAX = HOUR_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] LD_HOUR,
  input  logic [7:0] LD_MIN,
  input  logic [7:0] LD_SEC,
  input  logic       start,
  input  logic       pause,
  output logic [6:0] SEC1,
  output logic [6:0] SEC10,
  output logic [6:0] MIN1,
  output logic [6:0] MIN10,
  output logic [6:0] HOUR1,
  output logic [6:0] HOUR10,
  output logic       RUN,
  output logic       ALARM,
  output logic       ERR
);

  state_t state_reg, state_next;
  logic   run_reg, alarm_reg, alarm_next, err_reg, err_next;
  logic   dec_en, ld_all, load_ok, count_zero, count_one;

  logic [23:0] ld_bus;
  logic [23:0] count_bus;
  logic [3:0]  digit [NUM_DIGITS];
  logic        en    [NUM_DIGITS];
  logic        borrow[NUM_DIGITS];
  logic [6:0]  seg   [NUM_DIGITS];

  assign ld_bus     = {LD_HOUR, LD_MIN, LD_SEC};
  assign load_ok    = bcd_ok(LD_SEC, 59) && bcd_ok(LD_MIN, 59) &&
                      bcd_ok(LD_HOUR, HOUR_MAX);
  assign count_zero = (count_bus == 24'h000000);
  assign count_one  = (count_bus == 24'h000001);

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_first
        assign en[gi] = dec_en;
      end else begin : g_chain
        assign en[gi] = borrow[gi-1];
      end

      bcd_down_digit #(.MAX(digit_max(gi))) u_digit (
        .clk    (clk),
        .rst    (rst),
        .en     (en[gi]),
        .ld     (ld_all),
        .ld_val (ld_bus[gi*4 +: 4]),
        .q      (digit[gi]),
        .borrow (borrow[gi])
      );

      assign count_bus[gi*4 +: 4] = digit[gi];

      week08_7segment u_seg (
        .bcd (digit[gi]),
        .seg (seg[gi])
      );
    end
  endgenerate

  // Any load strobe consumes the cycle, so a rejected load also blocks the tick.
  always_comb begin
    state_next = state_reg;
    alarm_next = 1'b0;
    err_next   = 1'b0;
    dec_en     = 1'b0;
    ld_all     = 1'b0;
    if (load) begin
      if (load_ok) begin
        ld_all     = 1'b1;
        state_next = ST_IDLE;
      end else begin
        err_next = 1'b1;
      end
    end else if (pause && state_reg == ST_RUN) begin
      state_next = ST_PAUSED;
    end else if (start && (state_reg == ST_IDLE || state_reg == ST_PAUSED)) begin
      if (count_zero) begin
        state_next = ST_EXPIRED;
        alarm_next = 1'b1;
      end else begin
        state_next = ST_RUN;
      end
    end else if (start && state_reg == ST_EXPIRED) begin
      alarm_next = 1'b1;
    end else if (tick && state_reg == ST_RUN) begin
      dec_en = 1'b1;
      if (count_one) begin
        state_next = ST_EXPIRED;
        alarm_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      run_reg   <= 1'b0;
      alarm_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= (state_next == ST_RUN);
      alarm_reg <= alarm_next;
      err_reg   <= err_next;
    end
  end

  assign SEC1   = seg[0];
  assign SEC10  = seg[1];
  assign MIN1   = seg[2];
  assign MIN10  = seg[3];
  assign HOUR1  = seg[4];
  assign HOUR10 = seg[5];
  assign RUN    = run_reg;
  assign ALARM  = alarm_reg;
  assign ERR    = err_reg;

endmodule

// File: tb/tb_countdown60_timer.sv
// Directed self-checking bench for countdown60_timer; expected times are
// written by hand as BCD HHMMSS and converted to segment codes by table lookup.
module tb_countdown60_timer;
  import countdown60_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] LD_HOUR = 8'h00, LD_MIN = 8'h00, LD_SEC = 8'h00;
  logic [6:0] SEC1, SEC10, MIN1, MIN10, HOUR1, HOUR10;
  logic       RUN, ALARM, ERR;

  int checks = 0;
  int errors = 0;
  int alarm_cnt;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  countdown60_timer #(.HOUR_MAX(11)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .LD_HOUR(LD_HOUR), .LD_MIN(LD_MIN), .LD_SEC(LD_SEC),
    .start(start), .pause(pause),
    .SEC1(SEC1), .SEC10(SEC10), .MIN1(MIN1), .MIN10(MIN10),
    .HOUR1(HOUR1), .HOUR10(HOUR10),
    .RUN(RUN), .ALARM(ALARM), .ERR(ERR)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] exp_segs(input logic [23:0] hms);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*7 +: 7] = SEG_TAB[hms[i*4 +: 4]];
    return r;
  endfunction

  function automatic logic [41:0] obs_segs();
    return {HOUR10, HOUR1, MIN10, MIN1, SEC10, SEC1};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_time(input string tag, input logic [23:0] hms);
    chk(tag, 48'(obs_segs()), 48'(exp_segs(hms)));
  endtask

  task automatic chk_state(input string tag, input state_t st);
    chk(tag, 48'(dut.state_reg), 48'(st));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    LD_HOUR = h; LD_MIN = m; LD_SEC = s; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cycle(); tick = 1'b0;
  endtask

  initial begin
    // Reset state
    cycle(); cycle();
    chk_time("rst_segs", 24'h000000);
    chk("rst_run", 48'(RUN), 48'd0);
    chk("rst_alarm", 48'(ALARM), 48'd0);
    chk("rst_err", 48'(ERR), 48'd0);
    rst = 1'b1;
    cycle();

    // 00:01:05 countdown to expiry
    do_load(8'h00, 8'h01, 8'h05);
    chk_time("ld_0105", 24'h000105);
    chk_state("ld_idle", ST_IDLE);
    chk("ld_err", 48'(ERR), 48'd0);
    pulse_start();
    chk("start_run", 48'(RUN), 48'd1);
    alarm_cnt = 0;
    tick = 1'b1;
    for (int i = 0; i < 65; i++) begin
      cycle();
      alarm_cnt += int'(ALARM);
      if (i == 4) chk_time("t5_0100", 24'h000100);
      if (i == 5) chk_time("t6_0059", 24'h000059);
    end
    tick = 1'b0;
    chk_time("t65_zero", 24'h000000);
    chk("t65_alarm", 48'(ALARM), 48'd1);
    chk_state("t65_expired", ST_EXPIRED);
    chk("t65_run", 48'(RUN), 48'd0);
    pulse_tick();
    alarm_cnt += int'(ALARM);
    chk("alarm_once", 48'(alarm_cnt), 48'd1);
    chk_time("exp_hold", 24'h000000);
    pulse_start();
    chk("exp_realarm", 48'(ALARM), 48'd1);
    chk_state("exp_stay", ST_EXPIRED);

    // 01:00:00 borrows through every field
    do_load(8'h01, 8'h00, 8'h00);
    chk_state("ld_exp_idle", ST_IDLE);
    pulse_start();
    pulse_tick();
    chk_time("borrow_5959", 24'h005959);

    // Rejected loads while running
    do_load(8'h00, 8'h61, 8'h00);
    chk("err_min61", 48'(ERR), 48'd1);
    chk_time("err_min_keep", 24'h005959);
    chk_state("err_min_state", ST_RUN);
    cycle();
    chk("err_clear", 48'(ERR), 48'd0);
    do_load(8'h00, 8'h00, 8'h0A);
    chk("err_sec0a", 48'(ERR), 48'd1);
    chk_time("err_sec_keep", 24'h005959);
    do_load(8'h12, 8'h00, 8'h00);
    chk("err_hour12", 48'(ERR), 48'd1);
    chk_state("err_hr_state", ST_RUN);

    // Pause with simultaneous tick, ignored ticks, resume
    pulse_tick();
    chk_time("run_5958", 24'h005958);
    pause = 1'b1; tick = 1'b1; cycle(); pause = 1'b0; tick = 1'b0;
    chk_state("pause_state", ST_PAUSED);
    chk_time("pause_nodec", 24'h005958);
    chk("pause_run", 48'(RUN), 48'd0);
    pulse_tick();
    chk_time("pause_ignore", 24'h005958);
    pulse_start();
    chk("resume_run", 48'(RUN), 48'd1);
    pulse_tick();
    chk_time("resume_5957", 24'h005957);

    // Zero load then start; load beats start
    do_load(8'h00, 8'h00, 8'h00);
    chk_state("zero_idle", ST_IDLE);
    pulse_start();
    chk_state("zero_expired", ST_EXPIRED);
    chk("zero_alarm", 48'(ALARM), 48'd1);
    cycle();
    chk("zero_alarm_end", 48'(ALARM), 48'd0);
    start = 1'b1;
    do_load(8'h11, 8'h59, 8'h59);
    start = 1'b0;
    chk_state("ldstart_idle", ST_IDLE);
    chk_time("ld_hourmax", 24'h115959);
    chk("ldstart_run", 48'(RUN), 48'd0);

    // Hour tens borrow
    do_load(8'h10, 8'h00, 8'h00);
    pulse_start();
    pulse_tick();
    chk_time("hour_borrow", 24'h095959);

    // Reset mid-countdown overrides strobes
    rst = 1'b0; tick = 1'b1; start = 1'b1;
    cycle();
    rst = 1'b1; tick = 1'b0; start = 1'b0;
    chk_state("mrst_idle", ST_IDLE);
    chk_time("mrst_segs", 24'h000000);
    chk("mrst_run", 48'(RUN), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
